// File: rtl/kernel_irq_ctrl_if.sv
// Register access port of the kernel interrupt controller: one-cycle write/read strobes
// and registered read data.
`timescale 1ns/1ps
interface kernel_irq_ctrl_if;
  logic        reg_wr;
  logic        reg_rd;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_wr, reg_rd, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_wr, reg_rd, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/kernel_irq_ctrl.sv
// Coalesces kernel-done edges by count/timeout into one host irq line; irq_out 2 cycles after a
// threshold event, read data 1 cycle after reg_rd; no backpressure, strobes are always accepted.
`timescale 1ns/1ps
module kernel_irq_ctrl #(
  parameter int ACK_LEN = 4
) (
  input  logic               dma_axi_aclk,
  input  logic               dma_axi_areset,
  input  logic               kernel_irq,
  output logic               kernel_ack,
  output logic               irq_out,
  kernel_irq_ctrl_if.slave   reg_if
);

  logic        r_irq_d;
  logic [31:0] r_ctrl;
  logic        r_pending;
  logic        r_ovf;
  logic [7:0]  r_event_cnt;
  logic [31:0] r_total;
  logic [15:0] r_timer;
  logic [3:0]  r_ack_cnt;
  logic        r_irq_out;
  logic [31:0] r_rdata;

  logic        w_event;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_wr_total;
  logic        w_clr;
  logic [7:0]  w_thresh_eff;
  logic [15:0] w_timeout;
  logic        w_armed;
  logic        w_timeout_hit;
  logic [7:0]  w_cnt_base;
  logic [7:0]  w_cnt_nxt;
  logic        w_pending_nxt;
  logic        w_ovf_nxt;
  logic [15:0] w_timer_nxt;
  logic [31:0] w_total_nxt;
  logic [31:0] w_rd_mux;

  assign w_event       = kernel_irq & ~r_irq_d;
  assign w_wr_ctrl     = reg_if.reg_wr && (reg_if.reg_addr == 2'd0);
  assign w_wr_status   = reg_if.reg_wr && (reg_if.reg_addr == 2'd1);
  assign w_wr_total    = reg_if.reg_wr && (reg_if.reg_addr == 2'd2);
  assign w_clr         = w_wr_status && reg_if.reg_wdata[0] && r_pending;
  assign w_thresh_eff  = (r_ctrl[15:8] == 8'd0) ? 8'd1 : r_ctrl[15:8];
  assign w_timeout     = r_ctrl[31:16];
  assign w_armed       = !r_pending && (r_event_cnt != 8'd0);
  assign w_timeout_hit = w_armed && (w_timeout != 16'd0) && (r_timer == w_timeout);

  // A host clear is applied before a coincident event is counted.
  always_comb begin
    w_cnt_base    = w_clr ? 8'd0 : r_event_cnt;
    w_cnt_nxt     = w_cnt_base;
    w_pending_nxt = w_clr ? 1'b0 : r_pending;
    w_ovf_nxt     = (w_wr_status && reg_if.reg_wdata[1]) ? 1'b0 : r_ovf;
    w_timer_nxt   = r_timer + 16'd1;
    w_total_nxt   = r_total;
    if (w_event) begin
      w_total_nxt = r_total + 32'd1;
      if (w_cnt_base == 8'hFF) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = w_cnt_base + 8'd1;
      end
      if (!w_pending_nxt && (({1'b0, w_cnt_base} + 9'd1) >= {1'b0, w_thresh_eff})) begin
        w_pending_nxt = 1'b1;
      end
    end
    if (w_timeout_hit) begin
      w_pending_nxt = 1'b1;
    end
    if (w_clr || !w_armed || w_timeout_hit) begin
      w_timer_nxt = 16'd0;
    end
    if (w_wr_total) begin
      w_total_nxt = w_event ? 32'd1 : 32'd0;
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (reg_if.reg_addr)
      2'd0:    w_rd_mux = r_ctrl;
      2'd1:    w_rd_mux = {8'd0, r_event_cnt, 14'd0, r_ovf, r_pending};
      2'd2:    w_rd_mux = r_total;
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge dma_axi_aclk or posedge dma_axi_areset) begin
    if (dma_axi_areset) begin
      r_irq_d     <= 1'b0;
      r_ctrl      <= 32'h0000_0100;
      r_pending   <= 1'b0;
      r_ovf       <= 1'b0;
      r_event_cnt <= 8'd0;
      r_total     <= 32'd0;
      r_timer     <= 16'd0;
      r_ack_cnt   <= 4'd0;
      r_irq_out   <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_irq_d     <= kernel_irq;
      r_pending   <= w_pending_nxt;
      r_ovf       <= w_ovf_nxt;
      r_event_cnt <= w_cnt_nxt;
      r_total     <= w_total_nxt;
      r_timer     <= w_timer_nxt;
      r_irq_out   <= r_pending & r_ctrl[0];
      if (w_wr_ctrl) begin
        r_ctrl <= reg_if.reg_wdata & 32'hFFFF_FF01;
      end
      if (w_clr) begin
        r_ack_cnt <= 4'(ACK_LEN);
      end else if (r_ack_cnt != 4'd0) begin
        r_ack_cnt <= r_ack_cnt - 4'd1;
      end
      if (reg_if.reg_rd) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign kernel_ack       = (r_ack_cnt != 4'd0);
  assign irq_out          = r_irq_out;
  assign reg_if.reg_rdata = r_rdata;

endmodule
